crossbar_switch_arb: RTL and testbench
======================================

# crossbar_switch_arb

Parametrised, registered NoC router crossbar with per-output round-robin arbitration and valid/ready flow control on every port. Each input flit carries its destination port index, so callers no longer drive separate demux/mux selects. A one-entry output register per port gives a fixed one-cycle latency at full throughput. The block sits between the router input buffers and the link drivers and replaces the combinational select-driven crossbar. Port order is N=0, S=1, W=2, E=3, L=4.

## Interface
- NUM_PORTS, 5, number of input and output ports (≥2)
- DATA_WIDTH, 16, flit width in bits
- DEST_W, $clog2(NUM_PORTS), destination index width (derived, not overridden)

- clk_i  in  1  clock, all logic on rising edge
- rst_n_i  in  1  reset; one clock, asynchronous, active-low
- in_data_i  in  NUM_PORTS*DATA_WIDTH  input flits; port p occupies slice [p*DATA_WIDTH +: DATA_WIDTH]
- in_dest_i  in  NUM_PORTS*DEST_W  destination output index per input
- in_tail_i  in  NUM_PORTS  last flit of packet; used only with CROSSBAR_SWITCH_ARB_LOCK_EN
- in_valid_i  in  NUM_PORTS  input flit valid
- in_ready_o  out  NUM_PORTS  input flit accepted this cycle when valid & ready
- out_data_o  out  NUM_PORTS*DATA_WIDTH  registered output flits
- out_valid_o  out  NUM_PORTS  output register holds a flit
- out_ready_i  in  NUM_PORTS  downstream accepts the flit
- err_o  out  NUM_PORTS  one-cycle pulse per input when an illegal flit is discarded

## Operation
- Legal request: input p requests output d when in_valid_i[p] is high, d = in_dest_i[p], d < NUM_PORTS and d != p.
- Illegal flit (d ≥ NUM_PORTS, or d == p U-turn): in_ready_o[p]=1 in the same cycle, the flit is discarded, and err_o[p] pulses on the following cycle. The flit never reaches any output.
- Output d can load when !out_valid_o[d] or out_ready_i[d].
- Each output has a round-robin arbiter with pointer ptr[d] holding the last-granted input. Search order is ptr+1, ptr+2, … modulo NUM_PORTS. The first requester found wins.
- ptr[d] updates to the winner only when a transfer actually occurs (grant & load).
- in_ready_o[p] = grant to p from its destination & that output can load. It is combinational from in_valid_i, in_dest_i and out_ready_i. The input side must not make in_valid_i depend on in_ready_o.
- On transfer, out_data_o[d] takes the flit and out_valid_o[d] is set.
- If out_valid_o[d] & out_ready_i[d] with no new grant, out_valid_o[d] clears. out_data_o[d] holds its last value.
- Outputs are fully independent, so up to NUM_PORTS transfers happen per cycle.
- Each input targets exactly one output, so there is no input conflict.

## Timing
- Reset values: out_valid_o=0, out_data_o=0, in_ready_o=0 (valids are ignored during reset), err_o=0, ptr[d]=NUM_PORTS-1 so input 0 has first priority, all locks IDLE.
- Latency: an input handshake in cycle t gives out_valid_o in cycle t+1.
- Throughput: one flit per output per cycle when out_ready_i is held high.
- Back-pressure: when out_valid_o[d]=1 and out_ready_i[d]=0, all in_ready_o for requesters of d are 0. out_data_o[d] and out_valid_o[d] are held stable.
- Simultaneous drain and load on the same output in one cycle: out_valid_o stays 1 and the data is replaced.
- Reset asserted mid-operation: all registers return to reset values immediately. Buffered flits are lost.

## Configuration
- Macro: CROSSBAR_SWITCH_ARB_LOCK_EN.
- Defined: each output runs a two-state FSM.
  - IDLE: normal round-robin arbitration. On a transfer with in_tail_i=0, go to LOCKED(owner=winner).
  - LOCKED: only the owner can be granted; other requesters wait. On the owner's transfer with in_tail_i=1, return to IDLE and set ptr to the owner.
  - The lock is not released while the owner is idle.
  - An illegal flit never locks an output.
- Undefined: in_tail_i is ignored, there is no lock state, and arbitration is per flit.

## Test plan
- Single route: L(4) sends flit 16'hA5A5 with dest 0 and out_ready_i=all 1s. Required: out_data_o[0]=A5A5 and out_valid_o[0]=1 exactly one cycle later; in_ready_o[4] high in the send cycle.
- Contention: inputs 1, 2, 3 continuously target output 4 with out_ready_i=1. Required: grant order 1,2,3,1,2,3; one flit per cycle.
- Back-pressure: out_ready_i[2]=0 for 5 cycles while input 0 holds flit 16'h1234 to dest 2. Required: out_data_o[2] is stable, in_ready_o[0]=0; after release, the flit is accepted with no duplicate.
- Illegal flit: input 3 sends dest 3, then dest 7. Required: both are accepted, err_o[3] pulses once per flit, and no out_valid_o rises.
- Parallel permutation: N→S, S→N, W→E, E→W and L→N all in one cycle. Required: four flits delivered in one cycle; L is stalled behind S's flit to N and delivered the next cycle.
- Lock (macro defined): input 0 sends a 3-flit packet to 4, tail on flit 3, while input 1 also targets 4. Required: input 0's flits are contiguous and input 1 is granted only after the tail. Reset asserted mid-packet clears the lock.

Source files
------------

// File: rtl/crossbar_switch_arb.sv
// Registered NoC crossbar: per-output round-robin arbitration, valid/ready on every port.
// Define CROSSBAR_SWITCH_ARB_LOCK_EN to hold an output for one packet until its tail flit.
module crossbar_switch_arb #(
  parameter int  NUM_PORTS  = 5,
  parameter int  DATA_WIDTH = 16,
  localparam int DEST_W     = $clog2(NUM_PORTS)
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data_i,
  input  logic [NUM_PORTS*DEST_W-1:0]     in_dest_i,
  input  logic [NUM_PORTS-1:0]            in_tail_i,
  input  logic [NUM_PORTS-1:0]            in_valid_i,
  output logic [NUM_PORTS-1:0]            in_ready_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data_o,
  output logic [NUM_PORTS-1:0]            out_valid_o,
  input  logic [NUM_PORTS-1:0]            out_ready_i,
  output logic [NUM_PORTS-1:0]            err_o
);
  localparam logic [DEST_W:0]   PORTS_EXT = (DEST_W+1)'(NUM_PORTS);
  localparam logic [DEST_W-1:0] LAST_PORT = DEST_W'(NUM_PORTS - 1);

  logic [DEST_W-1:0]    dest     [NUM_PORTS];
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] bad;
  logic [DEST_W-1:0]    ptr      [NUM_PORTS];
  logic [DEST_W-1:0]    win      [NUM_PORTS];
  logic [NUM_PORTS-1:0] win_vld;
  logic [NUM_PORTS-1:0] can_load;
  logic [NUM_PORTS-1:0] xfer;
  logic [NUM_PORTS-1:0] eligible [NUM_PORTS];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      dest[p] = in_dest_i[p*DEST_W +: DEST_W];
      req[p]  = in_valid_i[p] && ({1'b0, dest[p]} < PORTS_EXT) && (dest[p] != DEST_W'(p));
      bad[p]  = in_valid_i[p] && !req[p];
    end
  end

`ifdef CROSSBAR_SWITCH_ARB_LOCK_EN
  // state  | meaning
  // IDLE   | round-robin among all requesters of this output
  // LOCKED | only the packet owner may be granted until its tail transfers
  typedef enum logic {IDLE, LOCKED} lock_state_t;

  lock_state_t       lock_q  [NUM_PORTS];
  lock_state_t       lock_d  [NUM_PORTS];
  logic [DEST_W-1:0] owner_q [NUM_PORTS];
  logic [DEST_W-1:0] owner_d [NUM_PORTS];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int d = 0; d < NUM_PORTS; d++) begin
        lock_q[d]  <= IDLE;
        owner_q[d] <= '0;
      end
    end else begin
      for (int d = 0; d < NUM_PORTS; d++) begin
        lock_q[d]  <= lock_d[d];
        owner_q[d] <= owner_d[d];
      end
    end
  end

  always_comb begin
    for (int d = 0; d < NUM_PORTS; d++) begin
      eligible[d] = (lock_q[d] == LOCKED) ? (NUM_PORTS'(1) << owner_q[d]) : '1;
    end
  end

  always_comb begin
    for (int d = 0; d < NUM_PORTS; d++) begin
      lock_d[d]  = lock_q[d];
      owner_d[d] = owner_q[d];
      case (lock_q[d])
        IDLE: begin
          if (xfer[d] && !in_tail_i[win[d]]) begin
            lock_d[d]  = LOCKED;
            owner_d[d] = win[d];
          end
        end
        LOCKED: begin
          if (xfer[d] && in_tail_i[win[d]]) lock_d[d] = IDLE;
        end
        default: lock_d[d] = IDLE;
      endcase
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ^in_tail_i;

  always_comb begin
    for (int d = 0; d < NUM_PORTS; d++) eligible[d] = '1;
  end
`endif

  // Search starts just after the last-granted input, so the previous winner goes last.
  always_comb begin
    for (int d = 0; d < NUM_PORTS; d++) begin
      win_vld[d]  = 1'b0;
      win[d]      = ptr[d];
      can_load[d] = !out_valid_o[d] || out_ready_i[d];
      for (int k = 1; k <= NUM_PORTS; k++) begin
        automatic logic [DEST_W-1:0] c = DEST_W'((int'(ptr[d]) + k) % NUM_PORTS);
        if (!win_vld[d] && req[c] && (dest[c] == DEST_W'(d)) && eligible[d][c]) begin
          win_vld[d] = 1'b1;
          win[d]     = c;
        end
      end
      xfer[d] = rst_n_i && win_vld[d] && can_load[d];
    end
  end

  // Illegal flits are swallowed immediately so they never block their input.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) in_ready_o[p] = rst_n_i && bad[p];
    for (int d = 0; d < NUM_PORTS; d++) begin
      if (xfer[d]) in_ready_o[win[d]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_o <= '0;
      out_data_o  <= '0;
      err_o       <= '0;
      for (int d = 0; d < NUM_PORTS; d++) ptr[d] <= LAST_PORT;
    end else begin
      err_o <= bad;
      for (int d = 0; d < NUM_PORTS; d++) begin
        if (xfer[d]) begin
          out_valid_o[d]                         <= 1'b1;
          out_data_o[d*DATA_WIDTH +: DATA_WIDTH] <= in_data_i[int'(win[d])*DATA_WIDTH +: DATA_WIDTH];
          ptr[d]                                 <= win[d];
        end else if (out_ready_i[d]) begin
          out_valid_o[d] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_crossbar_switch_arb.sv
// Bench for crossbar_switch_arb: directed scenarios plus random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_crossbar_switch_arb;
  localparam int N     = 5;
  localparam int DW    = 16;
  localparam int DESTW = $clog2(N);
`ifdef CROSSBAR_SWITCH_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic [N*DESTW-1:0] in_dest = '0;
  logic [N-1:0]    in_tail = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    out_ready = '0;
  logic [N-1:0]    in_ready, out_valid, err;
  logic [N*DW-1:0] out_data;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] m_data [N];
  bit            m_valid [N];
  int            m_ptr [N];
  bit            m_err [N];
  bit            m_lock [N];
  int            m_owner [N];
  int            m_win [N];
  logic [N-1:0]  exp_ready;
  logic [N-1:0]  seen_ready;
  logic [DW-1:0] cur [N];

  crossbar_switch_arb #(.NUM_PORTS(N), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_data_i   (in_data),
    .in_dest_i   (in_dest),
    .in_tail_i   (in_tail),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic int dest_of(input int p);
    return int'(in_dest[p*DESTW +: DESTW]);
  endfunction

  function automatic bit legal(input int p);
    return (dest_of(p) < N) && (dest_of(p) != p);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      m_data[d] = '0; m_valid[d] = 0; m_ptr[d] = N - 1; m_err[d] = 0;
      m_lock[d] = 0; m_owner[d] = 0; m_win[d] = -1;
    end
  endtask

  // Winner per output: first valid legal requester after the last grant, honouring a held lock.
  task automatic model_comb();
    for (int d = 0; d < N; d++) begin
      m_win[d] = -1;
      if (!m_valid[d] || out_ready[d]) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_ptr[d] + k) % N;
          if (m_win[d] < 0 && in_valid[c] && legal(c) && dest_of(c) == d &&
              (!m_lock[d] || c == m_owner[d]))
            m_win[d] = c;
        end
      end
    end
    exp_ready = '0;
    for (int p = 0; p < N; p++) if (in_valid[p] && !legal(p)) exp_ready[p] = 1'b1;
    for (int d = 0; d < N; d++) if (m_win[d] >= 0) exp_ready[m_win[d]] = 1'b1;
  endtask

  task automatic model_apply();
    for (int p = 0; p < N; p++) m_err[p] = in_valid[p] && !legal(p);
    for (int d = 0; d < N; d++) begin
      if (m_win[d] >= 0) begin
        m_data[d]  = in_data[m_win[d]*DW +: DW];
        m_valid[d] = 1;
        m_ptr[d]   = m_win[d];
        if (LOCK_EN) begin
          m_lock[d]  = !in_tail[m_win[d]];
          m_owner[d] = m_win[d];
        end
      end else if (out_ready[d]) begin
        m_valid[d] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0]    ev, ee;
    logic [N*DW-1:0] ed;
    for (int d = 0; d < N; d++) begin
      ev[d] = m_valid[d];
      ee[d] = m_err[d];
      ed[d*DW +: DW] = m_data[d];
    end
    check("out_valid", out_valid, ev);
    check("out_data", out_data, ed);
    check("err", err, ee);
  endtask

  task automatic step();
    #1;
    model_comb();
    seen_ready = in_ready;
    check("in_ready", in_ready, exp_ready);
    @(posedge clk);
    #1;
    model_apply();
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_ready", in_ready, '0);
    check_outputs();
    @(posedge clk);
    #1;
    check("rst_ready_hold", in_ready, '0);
    check_outputs();
    rst_n = 1'b1;
  endtask

  task automatic drive(input int p, input logic [DW-1:0] data, input int dest, input bit valid, input bit tail);
    in_data[p*DW +: DW]       = data;
    in_dest[p*DESTW +: DESTW] = DESTW'(dest);
    in_valid[p]               = valid;
    in_tail[p]                = tail;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) drive(p, DW'(16'h1000 + p), (p + 1) % N, 1, 1);
    out_ready = '1;
    do_reset();
    in_valid = '0;

    // single route L -> N
    drive(4, 16'hA5A5, 0, 1, 1);
    step();
    check("route_ready", seen_ready[4], 1'b1);
    check("route_data", out_data[0 +: DW], 16'hA5A5);
    check("route_valid", out_valid[0], 1'b1);
    in_valid = '0;
    step();

    // contention on output 4
    for (int p = 1; p <= 3; p++) begin
      cur[p] = DW'(p << 8);
      drive(p, cur[p], 4, 1, 1);
    end
    for (int i = 0; i < 6; i++) begin
      automatic int w = (i % 3) + 1;
      step();
      check("cont_grant", seen_ready, N'(1) << w);
      check("cont_data", out_data[4*DW +: DW], cur[w]);
      check("cont_valid", out_valid[4], 1'b1);
      cur[w] = cur[w] + 16'h1;
      drive(w, cur[w], 4, 1, 1);
    end
    in_valid = '0;
    step();

    // back-pressure on output 2
    drive(0, 16'h1111, 2, 1, 1);
    step();
    check("bp_pre", out_data[2*DW +: DW], 16'h1111);
    drive(0, 16'h1234, 2, 1, 1);
    out_ready[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_ready", seen_ready[0], 1'b0);
      check("bp_hold", out_data[2*DW +: DW], 16'h1111);
      check("bp_valid", out_valid[2], 1'b1);
    end
    out_ready[2] = 1'b1;
    step();
    check("bp_accept", seen_ready[0], 1'b1);
    check("bp_data", out_data[2*DW +: DW], 16'h1234);
    in_valid = '0;
    step();
    check("bp_nodup", out_valid[2], 1'b0);

    // illegal flits: U-turn then out-of-range
    drive(3, 16'hBAD3, 3, 1, 1);
    step();
    check("ill_uturn_rdy", seen_ready[3], 1'b1);
    check("ill_uturn_err", err[3], 1'b1);
    check("ill_uturn_out", out_valid, '0);
    in_valid = '0;
    step();
    check("ill_err_clr", err[3], 1'b0);
    drive(3, 16'hBAD7, 7, 1, 1);
    step();
    check("ill_range_rdy", seen_ready[3], 1'b1);
    check("ill_range_err", err[3], 1'b1);
    check("ill_range_out", out_valid, '0);
    in_valid = '0;
    step();
    check("ill_err_clr2", err[3], 1'b0);

    // parallel permutation with L behind S on output N
    drive(0, 16'h0001, 1, 1, 1);
    drive(1, 16'h0100, 0, 1, 1);
    drive(2, 16'h0203, 3, 1, 1);
    drive(3, 16'h0302, 2, 1, 1);
    drive(4, 16'h0400, 0, 1, 1);
    step();
    check("perm_ready", seen_ready, 5'b01111);
    check("perm_valid", out_valid, 5'b01111);
    check("perm_n", out_data[0*DW +: DW], 16'h0100);
    check("perm_s", out_data[1*DW +: DW], 16'h0001);
    check("perm_w", out_data[2*DW +: DW], 16'h0302);
    check("perm_e", out_data[3*DW +: DW], 16'h0203);
    in_valid = 5'b10000;
    step();
    check("perm_l_ready", seen_ready, 5'b10000);
    check("perm_l_data", out_data[0*DW +: DW], 16'h0400);
    check("perm_l_valid", out_valid, 5'b00001);
    in_valid = '0;
    step();

`ifdef CROSSBAR_SWITCH_ARB_LOCK_EN
    // packet lock on output 4
    drive(0, 16'hC000, 4, 1, 0);
    drive(1, 16'hD000, 4, 1, 1);
    step();
    check("lock_f0", seen_ready, 5'b00001);
    drive(0, 16'hC001, 4, 1, 0);
    step();
    check("lock_f1", seen_ready, 5'b00001);
    drive(0, 16'hC002, 4, 1, 1);
    step();
    check("lock_f2", seen_ready, 5'b00001);
    check("lock_tail_data", out_data[4*DW +: DW], 16'hC002);
    in_valid[0] = 1'b0;
    step();
    check("lock_release", seen_ready, 5'b00010);
    check("lock_other_data", out_data[4*DW +: DW], 16'hD000);
    in_valid = '0;
    step();
    drive(0, 16'hC010, 4, 1, 0);
    step();
    check("lock_again", seen_ready, 5'b00001);
    in_valid = '0;
    step();
    do_reset();
    drive(1, 16'hD001, 4, 1, 1);
    step();
    check("lock_rst_clear", seen_ready, 5'b00010);
    in_valid = '0;
    step();
`endif

    // random traffic, with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < N; p++)
        drive(p, DW'($urandom), int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) != 0);
      out_ready = N'($urandom);
      step();
      if (i == 200) do_reset();
    end
    in_valid = '0;
    out_ready = '1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
